// File: rtl/layer_fifo.sv
// -----------------------------------------------------------------------------
// layer_fifo
//   Inter-layer activation FIFO between chained conv stages. Reads are
//   first-word-fall-through: rd_data always shows the head entry while
//   empty is low. This FIFO supports:
//     - any DEPTH >= 1, including non-power-of-2 sizes
//     - almost-full and almost-empty thresholds, each limited to DEPTH
//     - an occupancy count output
//     - a synchronous flush
//     - sticky overflow and underflow error flags
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   wr_data      write data
//   wr_en        write request
//   rd_en        read request; pops the head entry
//   flush        synchronous clear of contents and pointers
//   clr_err      synchronous clear of the sticky error flags
//   rd_data      head entry; valid only while empty is low
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= limited almost-full threshold
//   almost_empty count <= limited almost-empty threshold
//   count        current occupancy
//   overflow     sticky: a write was dropped
//   underflow    sticky: a read was ignored
// -----------------------------------------------------------------------------
module layer_fifo #(
    parameter int DATA_WIDTH         = 16,
    parameter int DEPTH              = 16,
    parameter int ALMOST_FULL_THRES  = 10,
    parameter int ALMOST_EMPTY_THRES = 1,
    localparam int CNT_W             = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    // A one-entry FIFO still needs a 1-bit pointer to index its array.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Thresholds above DEPTH could never be reached, so they are limited to DEPTH.
    localparam int AF_LVL_I = (ALMOST_FULL_THRES  > DEPTH) ? DEPTH : ALMOST_FULL_THRES;
    localparam int AE_LVL_I = (ALMOST_EMPTY_THRES > DEPTH) ? DEPTH : ALMOST_EMPTY_THRES;

    localparam logic [CNT_W-1:0] AF_LVL    = CNT_W'(AF_LVL_I);
    localparam logic [CNT_W-1:0] AE_LVL    = CNT_W'(AE_LVL_I);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic             rd_ok;
    logic             wr_ok;

    // The wrap uses an explicit compare, so a non-power-of-2 DEPTH works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // All flags are decoded from the registered count. Because of this, no
    // flag depends combinationally on wr_en.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_CNT);
    assign almost_full  = (count_reg >= AF_LVL);
    assign almost_empty = (count_reg <= AE_LVL);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;
    assign rd_data      = mem[rd_ptr_reg];

    always_comb begin
        // Flush has priority over both requests. A write to a full FIFO is
        // still accepted when a pop frees a slot in the same cycle.
        rd_ok = rd_en & ~empty & ~flush;
        wr_ok = wr_en & (~full | rd_ok) & ~flush;

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_ok) wr_ptr_next = ptr_inc(wr_ptr_reg);
            if (rd_ok) rd_ptr_next = ptr_inc(rd_ptr_reg);
            case ({wr_ok, rd_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end

        // If a new error occurs in the same cycle as clr_err, the new error
        // is kept. Flush never raises an error.
        overflow_next  = (overflow_reg  & ~clr_err) | (wr_en & ~wr_ok & ~flush);
        underflow_next = (underflow_reg & ~clr_err) | (rd_en & empty  & ~flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // The storage array has no reset. A dropped or flushed write never
    // touches it.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: tb/tb_layer_fifo.sv
// -----------------------------------------------------------------------------
// tb_layer_fifo
//   Self-checking bench for layer_fifo with DEPTH=5, ALMOST_FULL_THRES=10
//   (limited to 5) and ALMOST_EMPTY_THRES=1. DEPTH=5 exercises the
//   non-power-of-2 pointer wrap.
//
//   The reference model holds the FIFO contents as a queue plus two error
//   bits. A monitor on the falling edge does two things each cycle:
//     - compares every DUT output with the model;
//     - applies that cycle's inputs to the model; each popped entry is
//       checked against the head of the queue.
//   Stimulus is a set of directed scenarios followed by random traffic.
// -----------------------------------------------------------------------------
module tb_layer_fifo;

    localparam int DW       = 16;
    localparam int DEPTH    = 5;
    localparam int AF_THRES = 10;
    localparam int AE_THRES = 1;
    localparam int CNT_W    = $clog2(DEPTH + 1);
    localparam int AF_EFF   = (AF_THRES < DEPTH) ? AF_THRES : DEPTH;
    localparam int AE_EFF   = (AE_THRES < DEPTH) ? AE_THRES : DEPTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    wr_data;
    logic             wr_en;
    logic             rd_en;
    logic             flush;
    logic             clr_err;
    logic [DW-1:0]    rd_data;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] model_q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    layer_fifo #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DEPTH),
        .ALMOST_FULL_THRES (AF_THRES),
        .ALMOST_EMPTY_THRES(AE_THRES)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .flush       (flush),
        .clr_err     (clr_err),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor and scoreboard. This block compares the DUT with the model,
    // then advances the model by the inputs that the next rising edge applies.
    always @(negedge clk) begin
        int   sz;
        logic rd_acc;
        logic wr_acc;
        logic [DW-1:0] head;
        if (rst) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        sz = model_q.size();
        check("count",        32'(count),        32'(sz));
        check("empty",        32'(empty),        32'(sz == 0));
        check("full",         32'(full),         32'(sz == DEPTH));
        check("almost_full",  32'(almost_full),  32'(sz >= AF_EFF));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AE_EFF));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        if (sz > 0) check("rd_data_head", 32'(rd_data), 32'(model_q[0]));

        if (!rst) begin
            if (flush) begin
                model_q.delete();
                if (clr_err) begin
                    m_ovf = 1'b0;
                    m_udf = 1'b0;
                end
            end else begin
                rd_acc = rd_en && (sz > 0);
                wr_acc = wr_en && ((sz < DEPTH) || rd_acc);
                if (rd_acc) begin
                    head = model_q.pop_front();
                    check("pop_data", 32'(rd_data), 32'(head));
                    $display("%0t pop  data=%h count=%0d", $time, rd_data, count);
                end
                if (wr_acc) begin
                    model_q.push_back(wr_data);
                    $display("%0t push data=%h count=%0d", $time, wr_data, count);
                end
                if (clr_err) begin
                    m_ovf = 1'b0;
                    m_udf = 1'b0;
                end
                if (wr_en && !wr_acc) m_ovf = 1'b1;
                if (rd_en && sz == 0) m_udf = 1'b1;
            end
        end
    end

    // Drive one cycle of inputs just after a rising edge. The inputs take
    // effect at the next rising edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic f, input logic c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        wr_data = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to full, then attempt one more write, which must be dropped.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(16'hA000 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hEEEE, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Read from the empty FIFO, then clear the sticky flags.
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();

        // Write and read together while full. The new word ends up last.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(16'hB000 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Write on empty with rd_en set. The write is accepted and the read
        // is an underflow.
        cyc(1'b1, 16'hC0DE, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        idle();

        // At count=3, flush with a write in the same cycle. Then write Y.
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'hD000 + i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'hBAD0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
        idle();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stream 23 words with reads interleaved, so the pointers wrap.
        for (int i = 0; i < 23; i++) begin
            cyc(1'b1, DW'(16'h2300 + i), (i % 3) != 0, 1'b0, 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Random traffic. The bias switches between write-heavy and read-heavy
        // phases, so the FIFO swings between full and empty.
        for (int i = 0; i < 2000; i++) begin
            logic wbit, rbit, fbit, cbit;
            if (((i / 150) % 2) == 0) begin
                wbit = ($urandom_range(0, 99) < 75);
                rbit = ($urandom_range(0, 99) < 35);
            end else begin
                wbit = ($urandom_range(0, 99) < 35);
                rbit = ($urandom_range(0, 99) < 75);
            end
            fbit = ($urandom_range(0, 59) == 0);
            cbit = ($urandom_range(0, 29) == 0);
            cyc(wbit, DW'($urandom), rbit, fbit, cbit);
        end

        // Assert reset mid-stream, away from a clock edge. The contents must
        // be discarded at once.
        idle();
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'hF000 + i), 1'b0, 1'b0, 1'b0);
        wr_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_full",  32'(full),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Traffic after reset.
        for (int i = 0; i < 200; i++) begin
            cyc($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1,
                1'b0, $urandom_range(0, 19) == 0);
        end
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
